// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Performance counters in the top are built only when HAZ_PERF_CNT_EN is defined.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hazard_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int RA_W_DEFAULT = 5;

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Forwarding select for one ALU operand: EX/MEM result wins over MEM/WB,
// and register 0 is never forwarded.
module fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = RA_W_DEFAULT
) (
    input  logic [RA_W-1:0] src,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    output logic [1:0]      sel
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == src);
    assign wb_hit  = wb_reg_write && (wb_rd != '0) && (wb_rd == src);

    always_comb begin
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, load-use stalls, branch flushes,
// data-memory freezes, halt/drain/resume; perf counters under HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W      = RA_W_DEFAULT,
    parameter int DRAIN_CNT = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_uses_rt,
    input  logic [RA_W-1:0]  ex_rs,
    input  logic [RA_W-1:0]  ex_rt,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_reg_write,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_reg_write,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DC_W = $clog2(DRAIN_CNT + 1);

    hazard_state_t   state;
    hazard_state_t   state_nxt;
    logic [DC_W-1:0] drain_cnt;
    logic [DC_W-1:0] drain_cnt_nxt;

    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;
    logic       load_use;
    logic       freeze;
    logic       stall_ev;
    logic       flush_ev;

    logic c_pc_en, c_if_id_en, c_id_ex_en, c_ex_mem_en, c_mem_wb_en;
    logic c_if_id_flush, c_id_ex_flush;

    fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .src           (ex_rs),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_a_raw)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .src           (ex_rt),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_b_raw)
    );

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign freeze   = dmem_req && !dmem_ready;

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        stall_ev      = 1'b0;
        flush_ev      = 1'b0;
        c_pc_en       = 1'b0;
        c_if_id_en    = 1'b0;
        c_id_ex_en    = 1'b0;
        c_ex_mem_en   = 1'b0;
        c_mem_wb_en   = 1'b0;
        c_if_id_flush = 1'b0;
        c_id_ex_flush = 1'b0;

        if (state == HALTED) begin
            if (resume) begin
                state_nxt = RUN;
            end
        end else if (freeze) begin
            // Branch and load-use are not consumed while frozen; they are seen again on release.
            stall_ev = 1'b1;
            if (state == RUN) begin
                state_nxt = MEM_WAIT;
            end
        end else begin
            c_pc_en     = 1'b1;
            c_if_id_en  = 1'b1;
            c_id_ex_en  = 1'b1;
            c_ex_mem_en = 1'b1;
            c_mem_wb_en = 1'b1;
            if (ex_branch_taken) begin
                c_if_id_flush = 1'b1;
                c_id_ex_flush = 1'b1;
                flush_ev      = 1'b1;
            end else if (load_use) begin
                c_pc_en       = 1'b0;
                c_if_id_en    = 1'b0;
                c_id_ex_flush = 1'b1;
                stall_ev      = 1'b1;
            end

            if (state == DRAIN) begin
                // Keep fetch blocked while ID..WB empty out; a taken branch still redirects the PC.
                c_if_id_flush = 1'b1;
                if (!ex_branch_taken) begin
                    c_pc_en = 1'b0;
                end
                if (!stall_ev) begin
                    drain_cnt_nxt = drain_cnt - DC_W'(1);
                    if (drain_cnt == DC_W'(1)) begin
                        state_nxt = HALTED;
                    end
                end
            end else begin
                state_nxt = RUN;
                if (!ex_branch_taken && !load_use && halt_req) begin
                    c_pc_en       = 1'b0;
                    c_if_id_flush = 1'b1;
                    drain_cnt_nxt = DC_W'(DRAIN_CNT);
                    state_nxt     = DRAIN;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Reset forces every control output low in the same cycle, before any clock edge.
    assign pc_en       = !rst && c_pc_en;
    assign if_id_en    = !rst && c_if_id_en;
    assign id_ex_en    = !rst && c_id_ex_en;
    assign ex_mem_en   = !rst && c_ex_mem_en;
    assign mem_wb_en   = !rst && c_mem_wb_en;
    assign if_id_flush = !rst && c_if_id_flush;
    assign id_ex_flush = !rst && c_id_ex_flush;
    assign fwd_a       = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b       = rst ? FWD_RF : fwd_b_raw;
    assign halted      = !rst && (state == HALTED);

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_ev && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    logic unused_perf;
    assign unused_perf  = stall_ev ^ flush_ev;
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for single-cycle decisions,
// hand-written sequences for freeze, halt/drain/resume and mid-operation reset.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int RA_W  = 5;
    localparam int CNT_W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [RA_W-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic            id_uses_rt, ex_mem_read, ex_branch_taken;
    logic            mem_reg_write, wb_reg_write;
    logic            dmem_req, dmem_ready, halt_req, resume;
    logic            pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic            if_id_flush, id_ex_flush, halted;
    logic [1:0]      fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    pipeline_hazard_ctrl #(.RA_W(RA_W), .DRAIN_CNT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .halt_req(halt_req), .resume(resume),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    // ctl bit order: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
    localparam logic [6:0] CTL_RUN   = 7'b1111100;
    localparam logic [6:0] CTL_STALL = 7'b0011101;
    localparam logic [6:0] CTL_BR    = 7'b1111111;
    localparam logic [6:0] CTL_DRAIN = 7'b0111110;
    localparam logic [6:0] CTL_DRLU  = 7'b0011111;
    localparam logic [6:0] CTL_OFF   = 7'b0000000;

    typedef struct {
        logic [RA_W-1:0] id_rs, id_rt;
        logic            id_uses_rt;
        logic [RA_W-1:0] ex_rs, ex_rt, ex_rd;
        logic            ex_mem_read, br;
        logic [RA_W-1:0] mem_rd;
        logic            mem_wr;
        logic [RA_W-1:0] wb_rd;
        logic            wb_wr;
        logic [6:0]      exp_ctl;
        logic [1:0]      exp_a, exp_b;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [6:0] ctl();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush};
    endfunction

    function automatic int perf(input int n);
`ifdef HAZ_PERF_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_counters(input string name);
        chk({name, "_stall_cycles"}, stall_cycles, perf(exp_stall));
        chk({name, "_flush_count"}, flush_count, perf(exp_flush));
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_rd = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rt = v.id_uses_rt;
        ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_rd = v.ex_rd;
        ex_mem_read = v.ex_mem_read; ex_branch_taken = v.br;
        mem_rd = v.mem_rd; mem_reg_write = v.mem_wr;
        wb_rd = v.wb_rd; wb_reg_write = v.wb_wr;
    endtask

    // Advance one clock and leave inputs safely after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
    endtask

    initial begin
        //          id_rs id_rt urt ex_rs ex_rt ex_rd lw br mem_rd mw wb_rd ww ctl        a        b
        vecs[0]  = '{5'd0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, CTL_RUN,   FWD_RF,  FWD_RF};
        vecs[1]  = '{5'd2, 5'd1, 1, 5'd0, 5'd0, 5'd2, 1, 0, 5'd0, 0, 5'd0, 0, CTL_STALL, FWD_RF,  FWD_RF};
        vecs[2]  = '{5'd0, 5'd0, 0, 5'd2, 5'd1, 5'd3, 0, 0, 5'd2, 1, 5'd0, 0, CTL_RUN,   FWD_MEM, FWD_RF};
        vecs[3]  = '{5'd0, 5'd0, 0, 5'd5, 5'd5, 5'd0, 0, 0, 5'd5, 1, 5'd5, 1, CTL_RUN,   FWD_MEM, FWD_MEM};
        vecs[4]  = '{5'd0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 5'd0, 1, CTL_RUN,   FWD_RF,  FWD_RF};
        vecs[5]  = '{5'd0, 5'd0, 0, 5'd3, 5'd7, 5'd0, 0, 0, 5'd7, 0, 5'd7, 1, CTL_RUN,   FWD_RF,  FWD_WB};
        vecs[6]  = '{5'd1, 5'd4, 1, 5'd6, 5'd4, 5'd4, 1, 0, 5'd6, 1, 5'd4, 1, CTL_STALL, FWD_MEM, FWD_WB};
        vecs[7]  = '{5'd1, 5'd4, 0, 5'd0, 5'd0, 5'd4, 1, 0, 5'd0, 0, 5'd0, 0, CTL_RUN,   FWD_RF,  FWD_RF};
        vecs[8]  = '{5'd0, 5'd0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0, 5'd0, 0, CTL_RUN,   FWD_RF,  FWD_RF};
        vecs[9]  = '{5'd8, 5'd0, 0, 5'd0, 5'd0, 5'd8, 1, 1, 5'd0, 0, 5'd0, 0, CTL_BR,    FWD_RF,  FWD_RF};
        vecs[10] = '{5'd0, 5'd0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 5'd0, 0, CTL_BR,    FWD_RF,  FWD_RF};
        vecs[11] = '{5'd2, 5'd0, 0, 5'd0, 5'd0, 5'd2, 0, 0, 5'd0, 0, 5'd0, 0, CTL_RUN,   FWD_RF,  FWD_RF};

        clear_inputs();
        // Reset values held while rst is high, even with active inputs.
        mem_rd = 5'd5; mem_reg_write = 1'b1; ex_rs = 5'd5; halt_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", ctl(), CTL_OFF);
        chk("rst_fwd_a", fwd_a, FWD_RF);
        chk("rst_halted", halted, 1'b0);
        chk("rst_state", dut.state, RUN);
        chk_counters("rst");
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();

        // Table of single-cycle decisions in RUN.
        for (int i = 0; i < 12; i++) begin
            apply_vec(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_ctl", i), ctl(), vecs[i].exp_ctl);
            chk($sformatf("vec%0d_fwd_a", i), fwd_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_fwd_b", i), fwd_b, vecs[i].exp_b);
            if (vecs[i].exp_ctl == CTL_STALL) exp_stall++;
            if (vecs[i].exp_ctl == CTL_BR) exp_flush++;
            next_cycle();
        end
        clear_inputs();
        #1;
        chk_counters("table");
        chk("table_state", dut.state, RUN);

        // Memory wait: three frozen cycles, then release with ready.
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("freeze%0d_ctl", i), ctl(), CTL_OFF);
            next_cycle();
            chk($sformatf("freeze%0d_state", i), dut.state, MEM_WAIT);
            exp_stall++;
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("release_ctl", ctl(), CTL_RUN);
        next_cycle();
        chk("release_state", dut.state, RUN);
        clear_inputs();
        chk_counters("freeze");

        // Load-use held through a freeze is seen again on release.
        dmem_req = 1'b1; load_use_inputs();
        @(negedge clk);
        chk("frz_lu_ctl", ctl(), CTL_OFF);
        next_cycle();
        exp_stall++;
        dmem_ready = 1'b1;
        @(negedge clk);
        chk("frz_lu_release_ctl", ctl(), CTL_STALL);
        next_cycle();
        exp_stall++;
        clear_inputs();
        #1;
        chk_counters("frz_lu");

        // Halt entry, drain with one load-use, halted, resume.
        halt_req = 1'b1;
        @(negedge clk);
        chk("halt_entry_ctl", ctl(), CTL_DRAIN);
        next_cycle();
        chk("halt_entry_state", dut.state, DRAIN);
        halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) load_use_inputs();
            @(negedge clk);
            chk($sformatf("drain%0d_ctl", i), ctl(), (i == 1) ? CTL_DRLU : CTL_DRAIN);
            chk($sformatf("drain%0d_halted", i), halted, 1'b0);
            next_cycle();
            if (i == 1) begin
                exp_stall++;
                clear_inputs();
            end
        end
        chk("halted_flag", halted, 1'b1);
        chk("halted_state", dut.state, HALTED);
        halt_req = 1'b1; dmem_req = 1'b1; ex_branch_taken = 1'b1;
        mem_rd = 5'd3; mem_reg_write = 1'b1; ex_rt = 5'd3;
        @(negedge clk);
        chk("halted_ctl", ctl(), CTL_OFF);
        chk("halted_fwd_b", fwd_b, FWD_MEM);
        next_cycle();
        chk("halted_hold", halted, 1'b1);
        clear_inputs();
        halt_req = 1'b1; resume = 1'b1;
        @(negedge clk);
        chk("resume_cycle_halted", halted, 1'b1);
        next_cycle();
        clear_inputs();
        #1;
        chk("post_resume_halted", halted, 1'b0);
        chk("post_resume_ctl", ctl(), CTL_RUN);
        chk_counters("halt");

        // Reset asserted while in MEM_WAIT.
        dmem_req = 1'b1;
        next_cycle();
        next_cycle();
        chk("pre_rst_memwait_state", dut.state, MEM_WAIT);
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_stall = 0; exp_flush = 0;
        chk("rst_memwait_ctl", ctl(), CTL_OFF);
        chk("rst_memwait_state", dut.state, RUN);
        chk_counters("rst_memwait");
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        chk("after_rst1_ctl", ctl(), CTL_RUN);

        // Reset asserted while in DRAIN.
        halt_req = 1'b1;
        next_cycle();
        halt_req = 1'b0;
        next_cycle();
        chk("pre_rst_drain_state", dut.state, DRAIN);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_drain_ctl", ctl(), CTL_OFF);
        chk("rst_drain_state", dut.state, RUN);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        next_cycle();
        chk("after_rst2_ctl", ctl(), CTL_RUN);
        chk("after_rst2_state", dut.state, RUN);
        chk_counters("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
